// File: rtl/fir_upsample_line.sv
// fir_upsample_line
// Zero-stuffing upsampler feeding the transmit FIR. One signed symbol is
// taken every OS enabled clocks through a ready/valid handshake. OS-1 zeros
// are inserted after each symbol. The newest FIR_LEN samples are exposed as
// one packed bus that matches the FIR's data-register input.
//
// Ports:
//   clk            : clock; all state changes on the rising edge
//   i_reset        : synchronous active-high reset
//   i_en           : global enable; when low, all state is frozen
//   i_flush        : clears the taps and the fill count; phase and underrun are kept
//   i_symbol       : signed input symbol
//   i_symbol_valid : i_symbol holds a valid symbol
//   o_symbol_ready : the symbol is accepted this cycle
//   o_data_reg     : packed taps; tap k is at [k*NB_IN +: NB_IN]; tap 0 is the newest
//   o_valid        : o_data_reg was updated at the last edge (last cycle's i_en)
//   o_phase        : phase of the sample now in tap 0
//   o_primed       : FIR_LEN samples have been shifted since reset or flush
//   o_underrun     : sticky flag; a symbol slot found no valid symbol
module fir_upsample_line #(
  parameter int FIR_LEN  = 21,
  parameter int NB_IN    = 8,
  parameter int OS       = 4,
  parameter int NB_PHASE = (OS > 1) ? $clog2(OS) : 1
) (
  input  logic                     clk,
  input  logic                     i_reset,
  input  logic                     i_en,
  input  logic                     i_flush,
  input  logic [NB_IN-1:0]         i_symbol,
  input  logic                     i_symbol_valid,
  output logic                     o_symbol_ready,
  output logic [FIR_LEN*NB_IN-1:0] o_data_reg,
  output logic                     o_valid,
  output logic [NB_PHASE-1:0]      o_phase,
  output logic                     o_primed,
  output logic                     o_underrun
);

  localparam int                   NB_FILL    = $clog2(FIR_LEN + 1);
  localparam logic [NB_PHASE-1:0]  PHASE_LAST = NB_PHASE'(OS - 1);
  localparam logic [NB_FILL-1:0]   FILL_FULL  = NB_FILL'(FIR_LEN);

  logic [NB_PHASE-1:0] phase_q, phase_d;
  logic [NB_PHASE-1:0] phaseOut_q, phaseOut_d;
  logic [NB_IN-1:0]    taps_q [FIR_LEN];
  logic [NB_IN-1:0]    taps_d [FIR_LEN];
  logic [NB_FILL-1:0]  fill_q, fill_d;
  logic                valid_q, valid_d;
  logic                underrun_q, underrun_d;

  logic                slot;
  logic                transfer;
  logic [NB_IN-1:0]    newSample;

  // Phase 0 is the only symbol slot. Ready depends only on registered
  // state and on the enable and reset inputs, never on i_symbol_valid.
  // This keeps it free of a combinational loop with the upstream source.
  assign slot           = (phase_q == '0);
  assign o_symbol_ready = i_en & slot & ~i_reset;
  assign transfer       = o_symbol_ready & i_symbol_valid;
  assign newSample      = transfer ? i_symbol : '0;

  // Phase counter: wraps at OS-1. With OS=1, PHASE_LAST is 0, so the
  // counter stays at 0 and every enabled cycle is a slot.
  always_comb begin
    phase_d = phase_q;
    if (i_en) begin
      if (phase_q == PHASE_LAST) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + NB_PHASE'(1);
      end
    end
  end

  // Delay line, fill count and flags. A flush zeroes the whole line in
  // place of the shift, so a symbol accepted in that cycle is dropped. The
  // handshake still completes, so the upstream source moves on. Underrun
  // checks the slot regardless of flush, because a flush does not excuse
  // a missing symbol.
  always_comb begin
    taps_d     = taps_q;
    fill_d     = fill_q;
    phaseOut_d = phaseOut_q;
    underrun_d = underrun_q;
    valid_d    = i_en;
    if (i_en) begin
      phaseOut_d = phase_q;
      if (slot && !i_symbol_valid) begin
        underrun_d = 1'b1;
      end
      if (i_flush) begin
        for (int k = 0; k < FIR_LEN; k++) begin
          taps_d[k] = '0;
        end
        fill_d = '0;
      end else begin
        taps_d[0] = newSample;
        for (int k = 1; k < FIR_LEN; k++) begin
          taps_d[k] = taps_q[k-1];
        end
        if (fill_q != FILL_FULL) begin
          fill_d = fill_q + NB_FILL'(1);
        end
      end
    end
  end

  // State register. Reset takes priority over everything. The freeze
  // behaviour of i_en=0 is already built into the *_d defaults above.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      phase_q    <= '0;
      phaseOut_q <= '0;
      fill_q     <= '0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
      for (int k = 0; k < FIR_LEN; k++) begin
        taps_q[k] <= '0;
      end
    end else begin
      phase_q    <= phase_d;
      phaseOut_q <= phaseOut_d;
      fill_q     <= fill_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
      taps_q     <= taps_d;
    end
  end

  // Pack the taps so that tap 0 sits in the least significant slice.
  for (genvar k = 0; k < FIR_LEN; k++) begin : gPack
    assign o_data_reg[k*NB_IN +: NB_IN] = taps_q[k];
  end

  assign o_valid    = valid_q;
  assign o_phase    = phaseOut_q;
  assign o_primed   = (fill_q == FILL_FULL);
  assign o_underrun = underrun_q;

endmodule

// File: doc/fir_upsample_line.md
# fir_upsample_line

Zero-stuffing upsampler and tapped delay line that sits directly upstream of the transmit FIR. It accepts one signed symbol every OS enabled clocks through a ready/valid handshake. It inserts OS-1 zeros between symbols and presents the last FIR_LEN samples as a packed parallel bus matching the FIR's data-register input. It also generates the FIR's valid strobe, a fill indication, and a sticky underrun flag.

## Interface
- FIR_LEN, 21, number of taps exposed on o_data_reg
- NB_IN, 8, sample width, signed S(NB_IN, NB_IN-1)
- OS, 4, oversampling factor (≥1); samples per symbol
- NB_PHASE, $clog2(OS) (min 1), phase counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_en  in  1  global enable; low freezes all state (taps, phase, fill, flags)
- i_flush  in  1  synchronous clear of taps and fill count; phase and underrun unaffected
- i_symbol  in  NB_IN  signed input symbol
- i_symbol_valid  in  1  i_symbol holds a valid symbol
- o_symbol_ready  out  1  block accepts i_symbol this cycle
- o_data_reg  out  FIR_LEN*NB_IN  packed taps; tap k at [k*NB_IN +: NB_IN]; tap 0 is the newest sample
- o_valid  out  1  o_data_reg was updated at the last edge; drives the FIR's valid input
- o_phase  out  NB_PHASE  phase of the sample currently in tap 0
- o_primed  out  1  FIR_LEN samples have been shifted since reset/flush
- o_underrun  out  1  sticky: a symbol slot found no valid symbol

## Operation
- Phase counter p counts 0..OS-1 and wraps to 0. It advances by 1 on every cycle with i_en=1 and i_reset=0.
- o_symbol_ready = i_en & (p==0) & ~i_reset. This is combinational from registered p, with no dependence on i_symbol_valid.
- Transfer occurs when o_symbol_ready & i_symbol_valid. No transfer occurs with i_en=0 or when p≠0.
- Each enabled cycle performs exactly one shift: tap[k] <= tap[k-1] for k=1..FIR_LEN-1, and tap[0] <= S, where:
  - p==0 with transfer: S = i_symbol.
  - p==0 without i_symbol_valid: S = 0, and o_underrun is set to 1. It stays at 1 until i_reset.
  - p≠0: S = 0; i_symbol is ignored.
- o_phase <= p at each shift, i.e. the phase of the sample now in tap 0.
- Fill counter: increments on each shift, saturates at FIR_LEN. o_primed = (fill == FIR_LEN).
- i_flush=1 (while i_en=1): all taps <= 0, fill <= 0, o_valid <= 1. p advances normally; any symbol transfer that cycle is discarded. The input is still accepted per the handshake, but tap 0 becomes 0.
- i_flush with i_en=0 has no effect.
- Priority: i_reset > i_en=0 (freeze) > i_flush > shift.
- OS=1: p is fixed at 0, ready = i_en, and every enabled cycle is a symbol slot.
- No arithmetic is performed; samples pass through bit-exact.

## Timing
- Reset values: all taps 0, p 0, o_phase 0, fill 0, o_valid 0, o_primed 0, o_underrun 0. o_symbol_ready is 0 while i_reset=1.
- o_valid is registered and equals the i_en value of the previous cycle (it is 0 in the cycle after reset). o_valid and o_data_reg change on the same edge.
- A symbol accepted at edge t appears in tap 0 after edge t. It reaches tap k after edge t+k, given continuous i_en.
- o_primed rises on the edge of the FIR_LEN-th shift after reset or flush.
- Setting i_en=0 mid-stream holds p, taps, and fill. Setting i_en=1 again resumes exactly where the block stopped, with no skipped or duplicated phase.
- Asserting reset mid-stream clears all state on the next edge. The next symbol slot is the first enabled cycle after reset deasserts.

## Test plan
- Reset, then i_en=1, OS=4, with symbols 0x40, 0xC0, 0x7F always valid:
  - ready pulses every 4th cycle, starting with the first enabled cycle.
  - Tap 0 sequence is 0x40,0,0,0,0xC0,0,0,0,0x7F.
  - 0x40 reaches tap 20 after 21 shifts, and o_primed rises on that edge.
- i_symbol_valid held 0 at one symbol slot:
  - tap 0 = 0 for that slot.
  - o_underrun goes to 1 and stays at 1 through later valid symbols until i_reset.
- Toggle i_en 1,0,0,1 during phase 2:
  - o_phase, taps, and fill hold for 2 cycles.
  - o_valid is 0 in the cycles after the disabled cycles.
  - ready next asserts exactly 2 enabled cycles after resume.
- Assert i_flush after the block is primed:
  - o_data_reg goes to all zeros and o_primed drops.
  - o_primed re-rises exactly 21 enabled cycles later.
  - The phase cadence is unchanged.
- Assert i_reset for 1 cycle mid-symbol (p=3):
  - next edge gives all outputs at reset values.
  - first cycle after release has ready=1 (p=0).
- OS=1, FIR_LEN=3:
  - ready = i_en every cycle.
  - inputs 1,2,3 give o_data_reg taps {3,2,1} after 3 edges, with o_primed=1.
